// File: rtl/cfu_exp_driver_if.sv
// CFU command/response channel between the batch driver and a custom function unit.
// Latency: none, this is wiring only.
// Backpressure: cmd_valid/cmd_ready on commands; responses are single-cycle pulses qualified by rsp_ready.
interface cfu_exp_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_payload_function_id,
        output cmd_payload_inputs_0,
        output cmd_payload_inputs_1,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_payload_function_id,
        input  cmd_payload_inputs_0,
        input  cmd_payload_inputs_1,
        output rsp_valid,
        input  rsp_ready,
        output rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_exp_driver.sv
// Batch driver: streams up to 16 buffered operands through a CFU, one command at a time, storing results and a running sum.
// Latency: per command 1 ISSUE cycle + CFU response delay + 1; job ends with a one-cycle done pulse.
// Backpressure: command held stable until cmd_ready; a per-command timeout aborts the job with error set.
module cfu_exp_driver #(
    parameter logic [9:0] FUNCT_ID = 10'd0,
    parameter int         TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [3:0]  load_index,
    input  logic [31:0] load_data,
    input  logic        start,
    input  logic [4:0]  count,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [3:0]  rd_index,
    output logic [31:0] rd_data,
    output logic [35:0] sum,
    cfu_exp_driver_if.master cfu
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q;
    logic [4:0]    cnt_q;
    logic [TW-1:0] tmo_q;
    logic [35:0]   sum_q;
    logic          err_q;

    logic [31:0]   in_buf  [16];
    logic [31:0]   res_buf [16];

    logic          count_legal;
    logic          last_entry;
    logic          start_ok;
    logic          start_bad;
    logic          rsp_take;
    logic          tmo_hit;

    assign count_legal = (count != 5'd0) && (count <= 5'd16);
    assign last_entry  = ({1'b0, idx_q} == (cnt_q - 5'd1));

    // State register; reset aborts any job immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and per-cycle event strobes. A response arriving on the final
    // timeout cycle still counts; a late accept on that cycle does not save the job.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        rsp_take  = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_legal) begin
                        start_ok = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        start_bad = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            ISSUE: begin
                if (tmo_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end else if (cfu.cmd_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (cfu.rsp_valid) begin
                    rsp_take = 1'b1;
                    state_d  = last_entry ? DONE : ISSUE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job bookkeeping: index, latched count, timeout counter, sum and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= 4'd0;
            cnt_q <= 5'd0;
            tmo_q <= '0;
            sum_q <= 36'd0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE || state_q == WAIT_RSP)
                tmo_q <= tmo_q + 1'b1;
            if (start_ok) begin
                idx_q <= 4'd0;
                cnt_q <= count;
                tmo_q <= '0;
                sum_q <= 36'd0;
                err_q <= 1'b0;
            end
            if (start_bad || tmo_hit)
                err_q <= 1'b1;
            if (rsp_take) begin
                sum_q <= sum_q + {4'd0, cfu.rsp_payload_outputs_0};
                if (!last_entry) begin
                    idx_q <= idx_q + 4'd1;
                    tmo_q <= '0;
                end
            end
        end
    end

    // Operand buffer: writable only while idle so an in-flight payload never changes.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && load_valid)
            in_buf[load_index] <= load_data;
    end

    // Result buffer: survives reset; entries past an aborted job keep old values.
    always_ff @(posedge clk) begin
        if (rsp_take)
            res_buf[idx_q] <= cfu.rsp_payload_outputs_0;
    end

    assign cfu.cmd_valid               = (state_q == ISSUE);
    assign cfu.cmd_payload_function_id = FUNCT_ID;
    assign cfu.cmd_payload_inputs_0    = (state_q == ISSUE) ? in_buf[idx_q] : 32'd0;
    assign cfu.cmd_payload_inputs_1    = 32'd0;
    assign cfu.rsp_ready               = (state_q == WAIT_RSP);

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign error   = err_q;
    assign sum     = sum_q;
    assign rd_data = res_buf[rd_index];

endmodule

// File: tb/tb_cfu_exp_driver.sv
// Self-checking bench for cfu_exp_driver: a CFU model with configurable stall/delay drives the channel,
// expected results/sum come from the values the model returned and the operands the bench loaded.
// Runs directed scenarios with randomized data: single, full batch, backpressure, illegal count, timeout, reset.
module tb_cfu_exp_driver;
    localparam logic [9:0] FID = 10'h1A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [3:0]  load_index = 4'd0;
    logic [31:0] load_data = 32'd0;
    logic        start = 1'b0;
    logic [4:0]  count = 5'd0;
    logic        busy, done, error;
    logic [3:0]  rd_index = 4'd0;
    logic [31:0] rd_data;
    logic [35:0] sum;

    cfu_exp_driver_if cfu();

    cfu_exp_driver #(.FUNCT_ID(FID), .TIMEOUT(256)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_index(load_index), .load_data(load_data),
        .start(start), .count(count),
        .busy(busy), .done(done), .error(error),
        .rd_index(rd_index), .rd_data(rd_data), .sum(sum),
        .cfu(cfu)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // CFU model controls and observations
    int          hold_cnt = 0;
    int          rsp_delay = 1;
    bit          never_rsp = 1'b0;
    bit          rand_rsp = 1'b0;
    bit          spurious = 1'b0;
    logic [31:0] fixed_val = 32'd0;
    logic [31:0] spur_val = 32'd0;
    logic [31:0] rsp_val_q = 32'd0;
    bit          rsp_pending = 1'b0;
    int          rsp_at = 0;
    logic [31:0] cmd_log[$];
    logic [31:0] rsp_log[$];
    int          accepts = 0, overlap = 0, stab_err = 0, fid_err = 0, in1_err = 0;
    int          done_cnt = 0, cv_cycles = 0, first_cv = 0;
    bit          prev_stall = 1'b0, prev_cv = 1'b0;
    logic [31:0] prev_p0 = 32'd0;

    // Reference state
    logic [31:0] exp_in [16];
    logic [31:0] exp_res [16];
    logic [35:0] exp_sum = 36'd0;

    // CFU behaviour: drives inputs at the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (rsp_pending && cyc == rsp_at && !never_rsp) begin
            cfu.rsp_valid = 1'b1;
            cfu.rsp_payload_outputs_0 = rsp_val_q;
            rsp_pending = 1'b0;
        end else if (spurious) begin
            cfu.rsp_valid = 1'b1;
            cfu.rsp_payload_outputs_0 = spur_val;
            spurious = 1'b0;
        end else begin
            cfu.rsp_valid = 1'b0;
            cfu.rsp_payload_outputs_0 = 32'hA5A5_0000 ^ cyc;
        end
        cfu.cmd_ready = (hold_cnt == 0);
        if (!cfu.cmd_ready && cfu.cmd_valid) hold_cnt--;
        if (prev_stall && cfu.cmd_valid && cfu.cmd_payload_inputs_0 !== prev_p0) stab_err++;
        if (cfu.cmd_valid && cfu.cmd_ready) begin
            if (rsp_pending) overlap++;
            if (cfu.cmd_payload_inputs_1 !== 32'd0) in1_err++;
            if (cfu.cmd_payload_function_id !== FID) fid_err++;
            cmd_log.push_back(cfu.cmd_payload_inputs_0);
            rsp_val_q = rand_rsp ? $urandom : fixed_val;
            rsp_log.push_back(rsp_val_q);
            rsp_pending = 1'b1;
            rsp_at = cyc + rsp_delay;
            accepts++;
        end
        prev_stall = cfu.cmd_valid && !cfu.cmd_ready;
        prev_p0 = cfu.cmd_payload_inputs_0;
        if (cfu.cmd_valid && !prev_cv) first_cv = cyc;
        prev_cv = cfu.cmd_valid;
        if (cfu.cmd_valid) cv_cycles++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] i, input logic [31:0] d);
        @(negedge clk);
        load_valid = 1'b1; load_index = i; load_data = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Pulse start, wait (bounded) for done, then one more cycle for the model to settle.
    task automatic run_job(input logic [4:0] n, input int budget, output int done_at);
        bit seen;
        done_at = -1;
        cmd_log.delete();
        rsp_log.delete();
        @(negedge clk);
        count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = (done === 1'b1);
        if (seen) done_at = cyc;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                done_at = cyc;
            end
        end
        chk("job_done_seen", {63'd0, seen}, 64'd1);
        @(negedge clk);
    endtask

    // Compare a completed legal job against the operands loaded and values returned.
    task automatic verify_job(input int n, input int done_before);
        chk("cmd_count", cmd_log.size(), n);
        for (int i = 0; i < n && i < cmd_log.size(); i++) begin
            chk("cmd_in0_order", cmd_log[i], exp_in[i]);
            exp_res[i] = rsp_log[i];
        end
        exp_sum = 36'd0;
        for (int i = 0; i < n && i < rsp_log.size(); i++) exp_sum = exp_sum + {4'd0, rsp_log[i]};
        chk("sum", sum, exp_sum);
        chk("error_clear", error, 1'b0);
        chk("done_pulses", done_cnt - done_before, 1);
        chk("busy_after_done", busy, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rd_index = i[3:0];
            #1;
            chk("result_buf", rd_data, exp_res[i]);
        end
    endtask

    initial begin
        int t_done;
        int d0, c0, a0;
        logic [4:0] n;
        bit seen;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_sum", sum, 36'd0);
        chk("rst_cmd_valid", cfu.cmd_valid, 1'b0);
        chk("rst_rsp_ready", cfu.rsp_ready, 1'b0);
        chk("rst_fid", cfu.cmd_payload_function_id, FID);
        chk("rst_in0", cfu.cmd_payload_inputs_0, 32'd0);
        chk("rst_in1", cfu.cmd_payload_inputs_1, 32'd0);
        reset = 1'b0;

        // Preload everything so the result model has defined values everywhere
        for (int i = 0; i < 16; i++) begin
            exp_in[i] = $urandom;
            load(i[3:0], exp_in[i]);
        end

        // Full batch of 16 with all-ones responses
        rand_rsp = 1'b0; fixed_val = 32'hFFFF_FFFF; rsp_delay = 2;
        d0 = done_cnt;
        run_job(5'd16, 400, t_done);
        verify_job(16, d0);
        chk("batch_sum", sum, 36'hF_FFFF_FFF0);
        chk("batch_overlap", overlap, 0);

        // Single command, long response delay
        exp_in[0] = 32'd0;
        load(4'd0, 32'd0);
        fixed_val = 32'h7FFF_FFF0; rsp_delay = 20;
        d0 = done_cnt;
        run_job(5'd1, 100, t_done);
        verify_job(1, d0);
        chk("single_sum", sum, 36'h0_7FFF_FFF0);

        // Random length, random operands and results, random delay
        for (int i = 0; i < 16; i++) begin
            exp_in[i] = $urandom;
            load(i[3:0], exp_in[i]);
        end
        rand_rsp = 1'b1; rsp_delay = $urandom_range(6, 1);
        n = 5'($urandom_range(15, 2));
        d0 = done_cnt;
        run_job(n, 400, t_done);
        verify_job(int'(n), d0);

        // Backpressure: 10 stalled cycles, response 3 cycles after accept
        rsp_delay = 3; hold_cnt = 10; stab_err = 0;
        c0 = cv_cycles; d0 = done_cnt;
        run_job(5'd1, 100, t_done);
        chk("bp_stable", stab_err, 0);
        chk("bp_valid_cycles", cv_cycles - c0, 11);
        verify_job(1, d0);

        // Spurious response while idle
        spur_val = 32'hDEAD_BEEF; spurious = 1'b1;
        repeat (5) @(negedge clk);
        chk("spur_sum", sum, exp_sum);
        rd_index = 4'd0; #1;
        chk("spur_result0", rd_data, exp_res[0]);

        // Illegal counts: immediate done with error, nothing issued, results kept
        c0 = cv_cycles; d0 = done_cnt;
        run_job(5'd0, 10, t_done);
        chk("cnt0_error", error, 1'b1);
        chk("cnt0_no_cmd", cv_cycles - c0, 0);
        chk("cnt0_done", done_cnt - d0, 1);
        chk("cnt0_sum_kept", sum, exp_sum);
        c0 = cv_cycles;
        run_job(5'd17, 10, t_done);
        chk("cnt17_error", error, 1'b1);
        chk("cnt17_no_cmd", cv_cycles - c0, 0);

        // Timeout: CFU never answers
        never_rsp = 1'b1; a0 = accepts; d0 = done_cnt;
        run_job(5'd3, 400, t_done);
        chk("tmo_latency", t_done - first_cv, 256);
        chk("tmo_error", error, 1'b1);
        chk("tmo_busy_after", busy, 1'b0);
        chk("tmo_done_pulses", done_cnt - d0, 1);
        chk("tmo_accepts", accepts - a0, 1);
        chk("tmo_sum", sum, 36'd0);
        exp_sum = 36'd0;
        for (int i = 0; i < 3; i++) begin
            rd_index = i[3:0]; #1;
            chk("tmo_result_kept", rd_data, exp_res[i]);
        end
        never_rsp = 1'b0; rsp_pending = 1'b0;

        // Legal job after errors clears the flag
        rsp_delay = $urandom_range(4, 1);
        n = 5'($urandom_range(16, 1));
        d0 = done_cnt;
        run_job(n, 400, t_done);
        verify_job(int'(n), d0);

        // Reset while waiting for a response: abort, no done, late response ignored
        rand_rsp = 1'b0; fixed_val = 32'h1234_5678; rsp_delay = 40;
        d0 = done_cnt;
        @(negedge clk);
        count = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cfu.rsp_ready === 1'b1) seen = 1'b1;
        end
        chk("rstjob_in_wait", {63'd0, seen}, 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstjob_cmd_valid", cfu.cmd_valid, 1'b0);
        chk("rstjob_rsp_ready", cfu.rsp_ready, 1'b0);
        chk("rstjob_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("rstjob_no_done", done_cnt - d0, 0);
        chk("rstjob_sum", sum, 36'd0);
        chk("rstjob_error", error, 1'b0);
        rd_index = 4'd0; #1;
        chk("rstjob_result_kept", rd_data, exp_res[0]);
        chk("fid_all_cmds", fid_err, 0);
        chk("in1_all_cmds", in1_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
